// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEF_W        = 64;
  localparam int DEF_NREGS    = 32;
  localparam int DEF_ZERO_REG = 31;

  typedef logic [DEF_W-1:0] word_t;

  // Address width for a register count; never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: write-first bypass, zero-register force, stall hold.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int NW       = 1,
  parameter int AW       = 5,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [W-1:0]     stored,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] wa,
  input  logic [NW*W-1:0]  wd,
  output logic [W-1:0]     rd
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [W-1:0] next_rd;

  // Later write ports override earlier ones, matching the storage priority.
  always_comb begin
    next_rd = stored;
    for (int k = 0; k < NW; k++) begin
      if (we[k] && (wa[k*AW +: AW] == addr)) begin
        next_rd = wd[k*W +: W];
      end
    end
    if (addr == ZR) begin
      next_rd = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
    end else if (en) begin
      rd <= next_rd;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NW write ports into shared storage, NR registered read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  W        = DEF_W,
  parameter int  NREGS    = DEF_NREGS,
  parameter int  NR       = 2,
  parameter int  NW       = 1,
  parameter int  ZERO_REG = DEF_ZERO_REG,
  parameter int  INIT_ID  = 1,
  localparam int AW       = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] wa,
  input  logic [NW*W-1:0]  wd,
  input  logic [NR-1:0]    re,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*W-1:0]  rd
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [W-1:0] regs [NREGS];

  // Port NW-1 is applied last so it wins a same-address conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (INIT_ID != 0 && i != ZERO_REG) ? W'(i) : '0;
      end
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (we[k] && (wa[k*AW +: AW] != ZR)) begin
          regs[wa[k*AW +: AW]] <= wd[k*W +: W];
        end
      end
    end
  end

  for (genvar j = 0; j < NR; j++) begin : g_rd
    logic [W-1:0] stored;

    assign stored = regs[ra[j*AW +: AW]];

    regfile_rdport #(
      .W        (W),
      .NW       (NW),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (re[j]),
      .addr   (ra[j*AW +: AW]),
      .stored (stored),
      .we     (we),
      .wa     (wa),
      .wd     (wd),
      .rd     (rd[j*W +: W])
    );

    a_ra_range : assert property (@(posedge clk) disable iff (!rst_n)
      re[j] |-> (int'(ra[j*AW +: AW]) < NREGS));
  end

  for (genvar k = 0; k < NW; k++) begin : g_wchk
    a_wa_range : assert property (@(posedge clk) disable iff (!rst_n)
      we[k] |-> (int'(wa[k*AW +: AW]) < NREGS));
  end

endmodule
